// File: rtl/ipif_rdfifo_responder.sv
// Read-FIFO responder for the IPIF push interface: buffers words pushed by user_logic
// and hands them to the bus side through a registered pop handshake.
module ipif_rdfifo_responder #(
  parameter int C_RDFIFO_DWIDTH = 64,
  parameter int C_DEPTH_LOG2    = 4,
  parameter int C_AF_THRESH     = 2
) (
  input  logic                       bus2ip_clk,
  input  logic                       bus2ip_resetn,
  input  logic                       ip2rfifo_wrreq,
  input  logic [C_RDFIFO_DWIDTH-1:0] ip2rfifo_data,
  output logic                       rfifo2ip_wrack,
  output logic                       rfifo2ip_full,
  output logic                       rfifo2ip_almostfull,
  input  logic                       rfifo_rdreq,
  output logic                       rfifo_rdack,
  output logic [C_RDFIFO_DWIDTH-1:0] rfifo_data,
  output logic                       rfifo_empty,
  output logic [C_DEPTH_LOG2:0]      rfifo_occupancy,
  input  logic                       rfifo_clr,
  output logic                       rfifo_underflow
);

  localparam int DEPTH = 1 << C_DEPTH_LOG2;
  localparam int OW    = C_DEPTH_LOG2 + 1;
  localparam int PW    = C_DEPTH_LOG2;

  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_AF   = OW'(DEPTH - C_AF_THRESH);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [C_RDFIFO_DWIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic [OW-1:0]              occ_q, occ_d;
  logic                       wrack_q, wrack_d;
  logic                       rdack_q, rdack_d;
  logic [C_RDFIFO_DWIDTH-1:0] data_q, data_d;
  logic                       full_q, full_d;
  logic                       af_q, af_d;
  logic                       empty_q, empty_d;
  logic                       underflow_q, underflow_d;

  logic push_fire;
  logic pop_fire;
  logic mem_we;

  // The ack cycle itself never fires, which is what gives the one-word-per-two-cycles rate.
  assign push_fire = ip2rfifo_wrreq & ~wrack_q & ~full_q;
  assign pop_fire  = rfifo_rdreq & ~rdack_q & ~empty_q;
  assign mem_we    = push_fire & ~rfifo_clr;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    data_d      = data_q;
    underflow_d = underflow_q;
    wrack_d     = push_fire;
    rdack_d     = pop_fire;

    if (rfifo_clr) begin
      // A flush discards any transfer in flight but still acks it so the requester moves on.
      wptr_d      = '0;
      rptr_d      = '0;
      occ_d       = '0;
      underflow_d = 1'b0;
    end else begin
      if (push_fire) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop_fire) begin
        rptr_d = rptr_q + PTR_ONE;
        data_d = mem_q[rptr_q];
      end
      if (rfifo_rdreq && !rdack_q && empty_q) begin
        underflow_d = 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end

    full_d  = (occ_d == OCC_FULL);
    af_d    = (occ_d >= OCC_AF);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge bus2ip_clk or negedge bus2ip_resetn) begin
    if (!bus2ip_resetn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      wrack_q     <= 1'b0;
      rdack_q     <= 1'b0;
      data_q      <= '0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      wrack_q     <= wrack_d;
      rdack_q     <= rdack_d;
      data_q      <= data_d;
      full_q      <= full_d;
      af_q        <= af_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset so it can map onto a RAM.
  always_ff @(posedge bus2ip_clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= ip2rfifo_data;
    end
  end

  assign rfifo2ip_wrack      = wrack_q;
  assign rfifo2ip_full       = full_q;
  assign rfifo2ip_almostfull = af_q;
  assign rfifo_rdack         = rdack_q;
  assign rfifo_data          = data_q;
  assign rfifo_empty         = empty_q;
  assign rfifo_occupancy     = occ_q;
  assign rfifo_underflow     = underflow_q;

endmodule

// File: tb/tb_ipif_rdfifo_responder.sv
// Self-checking bench for ipif_rdfifo_responder: randomized push/pop traffic compared
// against a queue-based model of the FIFO contents and flag rules.
module tb_ipif_rdfifo_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wrreq = 1'b0;
  logic [63:0] wdata = '0;
  logic        wrack;
  logic        full;
  logic        afull;
  logic        rdreq = 1'b0;
  logic        rdack;
  logic [63:0] rdata;
  logic        empty;
  logic [4:0]  occ;
  logic        clr = 1'b0;
  logic        underflow;

  logic [7:0]  dut_flags;
  assign dut_flags = {full, afull, empty, occ};

  int errors = 0;
  int checks = 0;
  logic [63:0] q[$];

  ipif_rdfifo_responder dut (
    .bus2ip_clk          (clk),
    .bus2ip_resetn       (resetn),
    .ip2rfifo_wrreq      (wrreq),
    .ip2rfifo_data       (wdata),
    .rfifo2ip_wrack      (wrack),
    .rfifo2ip_full       (full),
    .rfifo2ip_almostfull (afull),
    .rfifo_rdreq         (rdreq),
    .rfifo_rdack         (rdack),
    .rfifo_data          (rdata),
    .rfifo_empty         (empty),
    .rfifo_occupancy     (occ),
    .rfifo_clr           (clr),
    .rfifo_underflow     (underflow)
  );

  always #5 clk = ~clk;

  // Expected {full, almostfull, empty, occupancy} for a FIFO holding n words (depth 16, threshold 2).
  function automatic logic [7:0] exp_flags(input int n);
    logic [4:0] o;
    o = n[4:0];
    return {n == 16, n >= 14, n == 0, o};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle to let earlier acks retire, then hold the requested handshakes until acked or timed out.
  task automatic xact(input logic w, input logic [63:0] wd, input logic r, input int max_cycles,
                      output int wl, output int rl, output logic [63:0] rd);
    wl = 0;
    rl = 0;
    rd = '0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    step();
    wrreq = w;
    wdata = wd;
    rdreq = r;
    for (int i = 1; i <= max_cycles; i++) begin
      step();
      if (wrreq && wrack) begin
        wl = i;
        wrreq = 1'b0;
      end
      if (rdreq && rdack) begin
        rl = i;
        rdreq = 1'b0;
        rd = rdata;
      end
      if (!wrreq && !rdreq) break;
    end
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (5) step();
    checks++;
    if (dut_flags !== exp_flags(0))
      $display("[TB] FAIL reset_flags: got %h expected %h", dut_flags, exp_flags(0));
    checks++;
    if ({wrack, rdack, underflow} !== 3'b000)
      $display("[TB] FAIL reset_acks: got %b expected 000", {wrack, rdack, underflow});
    checks++;
    if (rdata !== 64'h0)
      $display("[TB] FAIL reset_data: got %h expected 0", rdata);
    errors += (dut_flags !== exp_flags(0)) + ({wrack, rdack, underflow} !== 3'b000) + (rdata !== 64'h0);
    q.delete();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int wl, rl;
    logic [63:0] rd, exp;
    exp = 64'h0123_4567_89ab_cdef;
    step();
    wrreq = 1'b1;
    wdata = exp;
    step();
    checks++;
    if (wrack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_wrack: got %b expected 1", wrack);
    end
    step();
    checks++;
    if ({wrack, occ} !== {1'b0, 5'd1}) begin
      errors++;
      $display("[TB] FAIL single_no_double: got wrack=%b occ=%0d expected wrack=0 occ=1", wrack, occ);
    end
    wrreq = 1'b0;
    q.push_back(exp);
    xact(1'b0, '0, 1'b1, 4, wl, rl, rd);
    exp = q.pop_front();
    checks++;
    if (rl !== 1) begin
      errors++;
      $display("[TB] FAIL single_rdack_lat: got %0d expected 1", rl);
    end
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("[TB] FAIL single_data: got %h expected %h", rd, exp);
    end
    checks++;
    if (dut_flags !== exp_flags(q.size())) begin
      errors++;
      $display("[TB] FAIL single_flags: got %h expected %h", dut_flags, exp_flags(q.size()));
    end
  endtask

  task automatic test_fill();
    int wl, rl;
    logic [63:0] rd, exp, extra;
    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 64'(i), 1'b0, 4, wl, rl, rd);
      q.push_back(64'(i));
      checks++;
      if (wl !== 1) begin
        errors++;
        $display("[TB] FAIL fill_wrack_%0d: got lat %0d expected 1", i, wl);
      end
      checks++;
      if (dut_flags !== exp_flags(q.size())) begin
        errors++;
        $display("[TB] FAIL fill_flags_%0d: got %h expected %h", i, dut_flags, exp_flags(q.size()));
      end
    end
    extra = rand64();
    xact(1'b1, extra, 1'b0, 4, wl, rl, rd);
    checks++;
    if (wl !== 0) begin
      errors++;
      $display("[TB] FAIL full_stall: got lat %0d expected no wrack", wl);
    end
    // Push held while full: the pop frees a slot first, so the push lands one cycle later.
    xact(1'b1, extra, 1'b1, 5, wl, rl, rd);
    exp = q.pop_front();
    q.push_back(extra);
    checks++;
    if (wl !== 2 || rl !== 1) begin
      errors++;
      $display("[TB] FAIL full_release: got wl=%0d rl=%0d expected wl=2 rl=1", wl, rl);
    end
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("[TB] FAIL full_release_data: got %h expected %h", rd, exp);
    end
    checks++;
    if (dut_flags !== exp_flags(q.size())) begin
      errors++;
      $display("[TB] FAIL full_refill_flags: got %h expected %h", dut_flags, exp_flags(q.size()));
    end
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, '0, 1'b1, 4, wl, rl, rd);
      exp = q.pop_front();
      checks++;
      if (rl !== 1 || rd !== exp) begin
        errors++;
        $display("[TB] FAIL drain_%0d: got lat %0d data %h expected lat 1 data %h", i, rl, rd, exp);
      end
    end
    checks++;
    if (dut_flags !== exp_flags(q.size())) begin
      errors++;
      $display("[TB] FAIL drain_flags: got %h expected %h", dut_flags, exp_flags(q.size()));
    end
  endtask

  task automatic test_wrap();
    int wl, rl;
    logic [63:0] rd, d, exp;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 10; i++) begin
        d = rand64();
        xact(1'b1, d, 1'b0, 4, wl, rl, rd);
        q.push_back(d);
        checks++;
        if (wl !== 1) begin
          errors++;
          $display("[TB] FAIL wrap_push_r%0d_%0d: got lat %0d expected 1", r, i, wl);
        end
      end
      for (int i = 0; i < 10; i++) begin
        xact(1'b0, '0, 1'b1, 4, wl, rl, rd);
        exp = q.pop_front();
        checks++;
        if (rl !== 1 || rd !== exp) begin
          errors++;
          $display("[TB] FAIL wrap_pop_r%0d_%0d: got lat %0d data %h expected lat 1 data %h", r, i, rl, rd, exp);
        end
      end
      checks++;
      if (dut_flags !== exp_flags(q.size())) begin
        errors++;
        $display("[TB] FAIL wrap_round_%0d: got %h expected %h", r, dut_flags, exp_flags(q.size()));
      end
    end
  endtask

  task automatic test_back_to_back();
    int wl, rl;
    logic [63:0] rd, d, exp;
    for (int i = 0; i < 5; i++) begin
      d = rand64();
      xact(1'b1, d, 1'b0, 4, wl, rl, rd);
      q.push_back(d);
    end
    for (int i = 0; i < 10; i++) begin
      d = rand64();
      xact(1'b1, d, 1'b1, 4, wl, rl, rd);
      exp = q.pop_front();
      q.push_back(d);
      checks++;
      if (wl !== 1 || rl !== 1 || rd !== exp) begin
        errors++;
        $display("[TB] FAIL simul_%0d: got wl=%0d rl=%0d data %h expected 1 1 %h", i, wl, rl, rd, exp);
      end
      checks++;
      if (dut_flags !== exp_flags(q.size())) begin
        errors++;
        $display("[TB] FAIL simul_flags_%0d: got %h expected %h", i, dut_flags, exp_flags(q.size()));
      end
    end
    for (int i = 0; i < 5; i++) begin
      xact(1'b0, '0, 1'b1, 4, wl, rl, rd);
      exp = q.pop_front();
      checks++;
      if (rl !== 1 || rd !== exp) begin
        errors++;
        $display("[TB] FAIL simul_drain_%0d: got lat %0d data %h expected lat 1 data %h", i, rl, rd, exp);
      end
    end
  endtask

  task automatic test_underflow_clear();
    int wl, rl;
    logic [63:0] rd, d;
    xact(1'b0, '0, 1'b1, 3, wl, rl, rd);
    checks++;
    if (rl !== 0 || underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow_set: got rl=%0d uf=%b expected rl=0 uf=1", rl, underflow);
    end
    // Push and pop together on an empty FIFO: the pop only succeeds once the word has landed.
    d = rand64();
    xact(1'b1, d, 1'b1, 4, wl, rl, rd);
    checks++;
    if (wl !== 1 || rl !== 2 || rd !== d) begin
      errors++;
      $display("[TB] FAIL empty_pushpop: got wl=%0d rl=%0d data %h expected 1 2 %h", wl, rl, rd, d);
    end
    for (int i = 0; i < 3; i++) begin
      d = rand64();
      xact(1'b1, d, 1'b0, 4, wl, rl, rd);
      q.push_back(d);
    end
    checks++;
    if (underflow !== 1'b1 || dut_flags !== exp_flags(q.size())) begin
      errors++;
      $display("[TB] FAIL underflow_sticky: got uf=%b flags %h expected uf=1 flags %h", underflow, dut_flags, exp_flags(q.size()));
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    q.delete();
    checks++;
    if (underflow !== 1'b0 || dut_flags !== exp_flags(0)) begin
      errors++;
      $display("[TB] FAIL clr: got uf=%b flags %h expected uf=0 flags %h", underflow, dut_flags, exp_flags(0));
    end
  endtask

  task automatic test_reset_mid();
    int wl, rl;
    logic [63:0] rd, d;
    for (int i = 0; i < 2; i++) begin
      d = rand64();
      xact(1'b1, d, 1'b0, 4, wl, rl, rd);
      q.push_back(d);
    end
    step();
    wrreq = 1'b1;
    wdata = rand64();
    rdreq = 1'b1;
    step();
    resetn = 1'b0;
    #1;
    q.delete();
    checks++;
    if ({wrack, rdack} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_acks: got %b expected 00", {wrack, rdack});
    end
    checks++;
    if (dut_flags !== exp_flags(0) || rdata !== 64'h0 || underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got flags %h data %h uf=%b expected %h 0 0", dut_flags, rdata, underflow, exp_flags(0));
    end
    wrreq = 1'b0;
    rdreq = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    d = rand64();
    xact(1'b1, d, 1'b0, 4, wl, rl, rd);
    q.push_back(d);
    checks++;
    if (wl !== 1 || dut_flags !== exp_flags(q.size())) begin
      errors++;
      $display("[TB] FAIL retry_push: got lat %0d flags %h expected 1 %h", wl, dut_flags, exp_flags(q.size()));
    end
    xact(1'b0, '0, 1'b1, 4, wl, rl, rd);
    d = q.pop_front();
    checks++;
    if (rl !== 1 || rd !== d) begin
      errors++;
      $display("[TB] FAIL retry_pop: got lat %0d data %h expected 1 %h", rl, rd, d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_underflow_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
